bcd_sseg_mux: RTL and testbench
===============================

# bcd_sseg_mux

Display stage downstream of the 13-bit binary-to-BCD converter. Captures the four BCD digits on the converter's completion pulse and time-multiplexes them onto a 4-digit common-anode seven-segment display with leading-zero blanking and per-digit decimal point. It also paces the converter: every `FRAMES_PER_CONV` display frames it issues a one-cycle start request, gated by the converter's `ready`.

## Interface
Parameters:
- `DWELL`, 50000: clock cycles each digit is driven (≥2).
- `FRAMES_PER_CONV`, 16: full 4-digit frames between conversion requests (≥1).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: reset, synchronous, active-low.
- `done_tick` in 1: converter completion pulse; digits are valid this cycle.
- `conv_ready` in 1: converter idle and able to accept a start.
- `bcd3` `bcd2` `bcd1` `bcd0` in 4 each: thousands, hundreds, tens and units digits.
- `blank_en` in 1: 1 enables leading-zero blanking.
- `dp_sel` in 4: active-high decimal-point enable per digit (bit i = digit i).
- `conv_start` out 1: one-cycle start pulse to the converter.
- `an` out 4: active-low anode enables, one-hot; bit i = digit i.
- `sseg` out 8: active-low segments {dp,g,f,e,d,c,b,a}.
- `frame_tick` out 1: one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Capture: `cap3..cap0` load `bcd3..bcd0` on every cycle in which `done_tick`=1, in any FSM state. Reset value is 0.
- Scan:
  - `dwell_cnt` counts 0..DWELL-1.
  - At DWELL-1 it wraps, and `idx` (2 bits) increments mod 4.
  - The `idx` 3→0 wrap asserts `frame_tick` for that cycle.
- Decode (active-low, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90. Any code 10–15 shows a dash, BF.
- Blanking:
  - Digit i (i≥1) is blank when `blank_en`=1 and `cap3..cap_i` are all zero.
  - Digit 0 is never blanked.
  - A blank digit drives segments a–g off, so `sseg`[6:0]=7F.
- Decimal point: `sseg`[7]=~`dp_sel`[idx], independent of blanking.
- Request FSM:
  - REQ: pending request.
    - If `conv_ready`=1: assert `conv_start` for one cycle, go to WAIT.
  - WAIT: `conv_start`=0.
    - On `done_tick`: clear `frame_cnt`, go to COUNT.
  - COUNT:
    - `frame_cnt` increments on each `frame_tick`.
    - When `frame_cnt` reaches FRAMES_PER_CONV-1 and `frame_tick`=1: go to REQ.
  - The reset state is REQ, so the first conversion starts immediately after reset.
- `done_tick` outside WAIT (a spurious or unrequested conversion) still captures the digits but does not change state.
- Never more than one `conv_start` is outstanding.

## Timing
- Reset values (cycle after `reset`=0 sampled):
  - `an`=4'b1110, `sseg`=8'hC0 (digit 0 shows 0), `conv_start`=0, `frame_tick`=0.
  - `idx`=0, `dwell_cnt`=0, `frame_cnt`=0, state=REQ.
- `an`, `sseg`, `conv_start` and `frame_tick` are registered.
- `an` and `sseg` reflect `idx` and `cap` one cycle after those registers change.
- Capture-to-display latency: one cycle after the `done_tick` edge for the digit currently scanned. Other digits update at their next dwell slot.
- `conv_start`: asserted in the cycle after REQ samples `conv_ready`=1, for exactly one cycle.
- Simultaneous events:
  - `done_tick` together with `frame_tick` in WAIT: capture, and `frame_cnt` clears to 0 (clear wins).
  - `done_tick` together with the frame-count terminal in COUNT: capture, and the transition to REQ proceeds.
- Reset mid-scan or mid-WAIT returns every register to its reset value next cycle. A later `done_tick` from the abandoned conversion is handled as out-of-WAIT.

## Structure
- Shared package `sseg_pkg` holds:
  - the segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - the FSM state encoding (REQ/WAIT/COUNT, 2 bits).
- One sub-module: `bcd_to_sseg`, a combinational 4-bit → 7-bit active-low decoder. The dash for codes >9 is produced inside it.
- Top holds the scan counter, capture registers, blanking logic, FSM and output registers.

## Test plan
Simulation parameters: DWELL=4, FRAMES_PER_CONV=2.
1. Reset, then `conv_ready`=1 → `conv_start` pulses once in the first cycle after reset release. `an`=1110 and `sseg`=C0 until the first dwell wrap.
2. `done_tick` with digits 1,2,3,4 and `blank_en`=0 → across one frame, `an`/`sseg` cycle through 1110/99, 1101/B0, 1011/A4, 0111/F9, each for 4 cycles. `frame_tick` fires every 16 cycles.
3. Digits 0,0,4,2 with `blank_en`=1 and `dp_sel`=0100 → digit 3 shows 7F, digit 2 shows 7F (blank, dp lit), digit 1 shows 99, digit 0 shows A4. With digits 0,0,0,0, digit 0 still shows C0.
4. Digit value 12 on `bcd1` → digit 1 shows BF.
5. Pacing: after `done_tick`, hold `conv_ready`=0 → no `conv_start` while it stays 0. Raise `conv_ready` → exactly one pulse, no earlier than 2 frames (32 cycles) after the `done_tick`.
6. Assert `reset`=0 mid-WAIT, then apply `done_tick` after release with the FSM in REQ → digits are captured, the state stays REQ, and exactly one `conv_start` follows.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants for the BCD seven-segment display stage: active-low
// segment patterns {g,f,e,d,c,b,a}, the request FSM encoding and blanking helper.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        COUNT = 2'd2
    } req_state_e;

    // Bit i set means digit i is a leading zero; the units digit always shows.
    function automatic logic [3:0] blank_mask(input logic [3:0][3:0] digits,
                                              input logic            enable);
        logic [3:0] mask;
        mask    = 4'b0000;
        mask[3] = enable && (digits[3] == 4'd0);
        mask[2] = mask[3] && (digits[2] == 4'd0);
        mask[1] = mask[2] && (digits[1] == 4'd0);
        return mask;
    endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 show a dash.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_sseg_mux.sv
// Captures converter BCD digits, scans them onto a 4-digit common-anode display
// and paces the converter with a start request every FRAMES_PER_CONV frames.
module bcd_sseg_mux
    import sseg_pkg::*;
#(
    parameter int DWELL           = 50000,
    parameter int FRAMES_PER_CONV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done_tick,
    input  logic       conv_ready,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       blank_en,
    input  logic [3:0] dp_sel,
    output logic       conv_start,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FCW = (FRAMES_PER_CONV > 1) ? $clog2(FRAMES_PER_CONV) : 1;
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_CONV - 1);

    logic [3:0][3:0] cap_q, cap_d;
    logic [DCW-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
    req_state_e      state_q, state_d;
    logic [3:0]      an_q, an_d;
    logic [7:0]      sseg_q, sseg_d;
    logic            conv_start_q, conv_start_d;
    logic            frame_tick_q, frame_tick_d;

    logic            dwell_wrap;
    logic [3:0]      scan_digit;
    logic [6:0]      scan_seg;
    logic [3:0]      blank_vec;

    always_comb begin
        cap_d = cap_q;
        if (done_tick) begin
            cap_d = {bcd3, bcd2, bcd1, bcd0};
        end
    end

    always_comb begin
        dwell_wrap   = (dwell_cnt_q == DWELL_LAST);
        dwell_cnt_d  = dwell_wrap ? '0 : dwell_cnt_q + DCW'(1);
        idx_d        = dwell_wrap ? idx_q + 2'd1 : idx_q;
        frame_tick_d = dwell_wrap && (idx_q == 2'd3);
    end

    always_comb begin
        scan_digit = cap_q[idx_q];
        blank_vec  = blank_mask(cap_q, blank_en);
    end

    bcd_to_sseg u_dec (
        .bcd (scan_digit),
        .seg (scan_seg)
    );

    // The decimal point is driven independently of blanking.
    always_comb begin
        an_d   = ~(4'b0001 << idx_q);
        sseg_d = {~dp_sel[idx_q], blank_vec[idx_q] ? SEG_BLANK : scan_seg};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ: begin
                if (conv_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_tick) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (frame_tick_q && (frame_cnt_q == FRAME_LAST)) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        conv_start_d = (state_q == REQ) && conv_ready;
    end

    // A done_tick arriving in WAIT restarts the frame count even on a frame_tick.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if ((state_q == WAIT) && done_tick) begin
            frame_cnt_d = '0;
        end else if ((state_q == COUNT) && frame_tick_q) begin
            frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_q        <= '0;
            dwell_cnt_q  <= '0;
            idx_q        <= 2'd0;
            frame_cnt_q  <= '0;
            an_q         <= 4'b1110;
            sseg_q       <= {1'b1, SEG_0};
            conv_start_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cap_q        <= cap_d;
            dwell_cnt_q  <= dwell_cnt_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            conv_start_q <= conv_start_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign conv_start = conv_start_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_sseg_mux.sv
// Scoreboard bench for bcd_sseg_mux: a cycle model pushes expected outputs on
// each rising edge and a monitor pops and compares them on the falling edge.
module tb_bcd_sseg_mux;

    localparam int DWELL   = 4;
    localparam int FPC     = 2;
    localparam int S_REQ   = 0;
    localparam int S_WAIT  = 1;
    localparam int S_COUNT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       done_tick;
    logic       conv_ready;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic       blank_en;
    logic [3:0] dp_sel;
    logic       conv_start;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       start;
        logic       ftick;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    exp_t m_out;

    int   checks_total  = 0;
    int   checks_passed = 0;

    int         m_dwell, m_idx, m_fcnt, m_state, m_state_nx;
    logic       m_ftick, m_ftick_nx, m_wrap;
    logic [3:0] m_cap [4];
    logic [7:0] seen_seg [4];

    bcd_sseg_mux #(
        .DWELL           (DWELL),
        .FRAMES_PER_CONV (FPC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .done_tick  (done_tick),
        .conv_ready (conv_ready),
        .bcd3       (bcd3),
        .bcd2       (bcd2),
        .bcd1       (bcd1),
        .bcd0       (bcd0),
        .blank_en   (blank_en),
        .dp_sel     (dp_sel),
        .conv_start (conv_start),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [7:0] model_seg(input int pos);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = pos; k < 4; k++) begin
            if (m_cap[k] != 4'd0) all_zero = 1'b0;
        end
        if (blank_en && (pos != 0) && all_zero) return {~dp_sel[pos], 7'h7F};
        return {~dp_sel[pos], digit_pattern(m_cap[pos])};
    endfunction

    // Reference model: registered outputs computed from pre-edge state.
    always @(posedge clk) begin
        if (!reset) begin
            m_dwell = 0;
            m_idx   = 0;
            m_fcnt  = 0;
            m_state = S_REQ;
            m_ftick = 1'b0;
            for (int k = 0; k < 4; k++) m_cap[k] = 4'd0;
            m_out = '{an: 4'b1110, sseg: 8'hC0, start: 1'b0, ftick: 1'b0};
        end else begin
            m_out.an    = ~(4'b0001 << m_idx);
            m_out.sseg  = model_seg(m_idx);
            m_out.start = (m_state == S_REQ) && conv_ready;
            m_wrap      = (m_dwell == DWELL - 1);
            m_ftick_nx  = m_wrap && (m_idx == 3);
            m_out.ftick = m_ftick_nx;
            m_state_nx  = m_state;
            case (m_state)
                S_REQ:   if (conv_ready) m_state_nx = S_WAIT;
                S_WAIT:  if (done_tick) begin
                             m_state_nx = S_COUNT;
                             m_fcnt     = 0;
                         end
                S_COUNT: if (m_ftick) begin
                             if (m_fcnt == FPC - 1) m_state_nx = S_REQ;
                             else m_fcnt = m_fcnt + 1;
                         end
                default: m_state_nx = S_REQ;
            endcase
            m_state = m_state_nx;
            m_ftick = m_ftick_nx;
            if (done_tick) begin
                m_cap[3] = bcd3;
                m_cap[2] = bcd2;
                m_cap[1] = bcd1;
                m_cap[0] = bcd0;
            end
            m_dwell = m_wrap ? 0 : m_dwell + 1;
            m_idx   = m_wrap ? (m_idx + 1) % 4 : m_idx;
        end
        sb_q.push_back(m_out);
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            checkOutput("sb_an", 32'(an), 32'(mon_exp.an));
            checkOutput("sb_sseg", 32'(sseg), 32'(mon_exp.sseg));
            checkOutput("sb_conv_start", 32'(conv_start), 32'(mon_exp.start));
            checkOutput("sb_frame_tick", 32'(frame_tick), 32'(mon_exp.ftick));
        end
    end

    task automatic applyStimulus(input logic done, input logic ready,
                                 input logic [3:0] d3, input logic [3:0] d2,
                                 input logic [3:0] d1, input logic [3:0] d0,
                                 input logic blank, input logic [3:0] dp);
        done_tick  = done;
        conv_ready = ready;
        bcd3       = d3;
        bcd2       = d2;
        bcd1       = d1;
        bcd0       = d0;
        blank_en   = blank;
        dp_sel     = dp;
    endtask

    task automatic pulse_done(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        applyStimulus(1'b1, conv_ready, d3, d2, d1, d0, blank_en, dp_sel);
        @(negedge clk);
        done_tick = 1'b0;
    endtask

    task automatic capture_frame();
        for (int k = 0; k < 4; k++) seen_seg[k] = 8'h00;
        for (int c = 0; c < 4 * DWELL; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: seen_seg[0] = sseg;
                4'b1101: seen_seg[1] = sseg;
                4'b1011: seen_seg[2] = sseg;
                4'b0111: seen_seg[3] = sseg;
                default: ;
            endcase
        end
    endtask

    task automatic count_starts(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (conv_start) cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_starts;
        int first_tick, second_tick, elapsed;
        logic found;

        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("reset_an", 32'(an), 32'h E);
        checkOutput("reset_sseg", 32'(sseg), 32'h C0);
        checkOutput("reset_conv_start", 32'(conv_start), 32'h0);
        checkOutput("reset_frame_tick", 32'(frame_tick), 32'h0);

        reset = 1'b1;
        @(negedge clk);
        checkOutput("start_after_reset", 32'(conv_start), 32'h1);
        @(negedge clk);
        checkOutput("start_one_cycle", 32'(conv_start), 32'h0);
        repeat (4) @(negedge clk);

        $display("[TB] digits 1,2,3,4 without blanking");
        pulse_done(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (2) @(negedge clk);
        capture_frame();
        checkOutput("d1234_dig0", 32'(seen_seg[0]), 32'h99);
        checkOutput("d1234_dig1", 32'(seen_seg[1]), 32'hB0);
        checkOutput("d1234_dig2", 32'(seen_seg[2]), 32'hA4);
        checkOutput("d1234_dig3", 32'(seen_seg[3]), 32'hF9);
        first_tick  = -1;
        second_tick = -1;
        for (int c = 0; c < 40 && second_tick < 0; c++) begin
            @(negedge clk);
            if (frame_tick) begin
                if (first_tick < 0) first_tick = c;
                else second_tick = c;
            end
        end
        checkOutput("frame_tick_seen", 32'(second_tick >= 0), 32'h1);
        if (second_tick >= 0) checkOutput("frame_tick_period", 32'(second_tick - first_tick), 32'd16);
        repeat (40) @(negedge clk);

        $display("[TB] leading-zero blanking and decimal point");
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0100);
        pulse_done(4'd0, 4'd0, 4'd4, 4'd2);
        repeat (2) @(negedge clk);
        capture_frame();
        checkOutput("blank_dig3_segs", 32'(seen_seg[3][6:0]), 32'h7F);
        checkOutput("blank_dig2_dp", 32'(seen_seg[2]), 32'h7F);
        checkOutput("blank_dig1", 32'(seen_seg[1]), 32'h99);
        checkOutput("blank_dig0", 32'(seen_seg[0]), 32'hA4);
        pulse_done(4'd0, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        capture_frame();
        checkOutput("zero_dig0_shown", 32'(seen_seg[0]), 32'hC0);
        checkOutput("zero_dig1_blank", 32'(seen_seg[1]), 32'hFF);
        repeat (40) @(negedge clk);

        $display("[TB] out-of-range digit shows a dash");
        applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0000);
        pulse_done(4'd0, 4'd0, 4'd12, 4'd5);
        repeat (2) @(negedge clk);
        capture_frame();
        checkOutput("dash_dig1", 32'(seen_seg[1]), 32'hBF);
        checkOutput("dash_dig0", 32'(seen_seg[0]), 32'h92);
        checkOutput("dash_dig3_zero", 32'(seen_seg[3]), 32'hC0);
        repeat (40) @(negedge clk);

        $display("[TB] pacing with conv_ready held low");
        conv_ready = 1'b0;
        pulse_done(4'd3, 4'd1, 4'd4, 4'd1);
        count_starts(40, n_starts);
        checkOutput("no_start_ready_low", 32'(n_starts), 32'd0);
        conv_ready = 1'b1;
        elapsed = 41;
        found   = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            elapsed++;
            if (conv_start) found = 1'b1;
        end
        checkOutput("start_after_ready", 32'(found), 32'h1);
        checkOutput("start_not_early", 32'(elapsed >= 32), 32'h1);
        count_starts(20, n_starts);
        checkOutput("single_start", 32'(n_starts), 32'd0);

        $display("[TB] reset during WAIT then stale done_tick");
        conv_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midreset_an", 32'(an), 32'hE);
        checkOutput("midreset_sseg", 32'(sseg), 32'hC0);
        reset = 1'b1;
        @(negedge clk);
        pulse_done(4'd9, 4'd8, 4'd7, 4'd6);
        count_starts(20, n_starts);
        checkOutput("stale_done_no_start", 32'(n_starts), 32'd0);
        capture_frame();
        checkOutput("stale_dig3", 32'(seen_seg[3]), 32'h90);
        checkOutput("stale_dig2", 32'(seen_seg[2]), 32'h80);
        checkOutput("stale_dig1", 32'(seen_seg[1]), 32'hF8);
        checkOutput("stale_dig0", 32'(seen_seg[0]), 32'h82);
        conv_ready = 1'b1;
        @(negedge clk);
        checkOutput("stale_start_pulse", 32'(conv_start), 32'h1);
        count_starts(30, n_starts);
        checkOutput("stale_single_start", 32'(n_starts), 32'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
